// File: rtl/pw_trigger_gen_pkg.sv
// Shared definitions for the trigger pulse generator and its register block.
// Holds the FSM state encoding and the default counter widths.
// No logic; imported with import pw_trigger_gen_pkg::*.
package pw_trigger_gen_pkg;

  // Default widths, kept here so the register block sizes its fields identically.
  localparam int TRIG_DELAY_WIDTH_DEF  = 20;
  localparam int TRIG_WIDTH_WIDTH_DEF  = 16;
  localparam int TRIG_REPEAT_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    TRIG_ST_IDLE  = 2'd0,
    TRIG_ST_DELAY = 2'd1,
    TRIG_ST_PULSE = 2'd2,
    TRIG_ST_GAP   = 2'd3
  } trig_state_e;

endpackage

// File: rtl/pw_down_counter.sv
// Purpose: loadable down-counter with zero flag; saturates at zero, never wraps.
// Latency: load/decrement take effect at the next fe_clk edge; zero is registered state.
// Backpressure: none; load has priority over decrement.
// Ports: fe_clk/reset_n clock and async active-low reset; load + load_val set the
//        count; dec decrements when nonzero; zero is high while the count is 0.
module pw_down_counter #(
  parameter int pWIDTH = 16
) (
  input  logic              fe_clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic [pWIDTH-1:0] load_val,
  input  logic              dec,
  output logic              zero
);

  localparam logic [pWIDTH-1:0] CNT_ONE = pWIDTH'(1);

  logic [pWIDTH-1:0] cnt_d;
  logic [pWIDTH-1:0] cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/pw_trigger_gen.sv
// Purpose: turns an armed match pulse into one delayed trigger pulse of programmable width.
// Latency: O_trigger rises D+1 cycles after the accepting edge, stays high W cycles, O_done follows.
// Backpressure: none; matches arriving while busy are dropped and flagged on sticky O_missed.
// Ports: fe_clk/reset_n; I_arm level gate; I_match single-cycle pulse; I_trigger_delay and
//        I_trigger_width latched at acceptance; O_trigger, O_busy, O_done, O_missed all registered.
// Optional: define PW_TRIGGER_REPEAT_EN to add I_repeat_count / I_repeat_gap and the GAP state
//        for a train of (repeat_count+1) pulses separated by repeat_gap low cycles (0 acts as 1).
module pw_trigger_gen
  import pw_trigger_gen_pkg::*;
#(
  parameter int pTRIGGER_DELAY_WIDTH = TRIG_DELAY_WIDTH_DEF,
  parameter int pTRIGGER_WIDTH_WIDTH = TRIG_WIDTH_WIDTH_DEF
`ifdef PW_TRIGGER_REPEAT_EN
  , parameter int pREPEAT_WIDTH      = TRIG_REPEAT_WIDTH_DEF
`endif
) (
  input  logic                            fe_clk,
  input  logic                            reset_n,
  input  logic                            I_arm,
  input  logic                            I_match,
  input  logic [pTRIGGER_DELAY_WIDTH-1:0] I_trigger_delay,
  input  logic [pTRIGGER_WIDTH_WIDTH-1:0] I_trigger_width,
`ifdef PW_TRIGGER_REPEAT_EN
  input  logic [pREPEAT_WIDTH-1:0]        I_repeat_count,
  input  logic [pTRIGGER_WIDTH_WIDTH-1:0] I_repeat_gap,
`endif
  output logic                            O_trigger,
  output logic                            O_busy,
  output logic                            O_done,
  output logic                            O_missed
);

  localparam logic [pTRIGGER_WIDTH_WIDTH-1:0] W_ONE = pTRIGGER_WIDTH_WIDTH'(1);

  trig_state_e state_d, state_q;
  logic [pTRIGGER_WIDTH_WIDTH-1:0] width_d, width_q;
  logic trig_d, trig_q;
  logic done_d, done_q;
  logic busy_d, busy_q;
  logic missed_d, missed_q;
  logic arm_d, arm_q;

  logic dly_load, dly_dec, dly_zero;
  logic wid_load, wid_dec, wid_zero;
  logic arm_rise;

`ifdef PW_TRIGGER_REPEAT_EN
  localparam logic [pREPEAT_WIDTH-1:0] R_ONE = pREPEAT_WIDTH'(1);
  logic [pREPEAT_WIDTH-1:0] rep_d, rep_q;
  // Stored as (gap - 1) with 0 mapped to 0, so a zero gap still gives one low cycle.
  logic [pTRIGGER_WIDTH_WIDTH-1:0] gap_d, gap_q;
  logic gap_load, gap_dec, gap_zero;
`endif

  assign arm_rise = I_arm & ~arm_q;
  assign arm_d    = I_arm;

  always_comb begin
    state_d  = state_q;
    width_d  = width_q;
    trig_d   = trig_q;
    done_d   = 1'b0;
    dly_load = 1'b0;
    dly_dec  = 1'b0;
    wid_load = 1'b0;
    wid_dec  = 1'b0;
`ifdef PW_TRIGGER_REPEAT_EN
    rep_d    = rep_q;
    gap_d    = gap_q;
    gap_load = 1'b0;
    gap_dec  = 1'b0;
`endif

    case (state_q)
      TRIG_ST_IDLE: begin
        if (I_match && I_arm) begin
          width_d  = I_trigger_width;
          dly_load = 1'b1;
          state_d  = TRIG_ST_DELAY;
`ifdef PW_TRIGGER_REPEAT_EN
          rep_d    = I_repeat_count;
          gap_d    = (I_repeat_gap == '0) ? '0 : (I_repeat_gap - W_ONE);
`endif
        end
      end
      TRIG_ST_DELAY: begin
        if (!dly_zero) begin
          dly_dec = 1'b1;
        end else if (width_q != '0) begin
          wid_load = 1'b1;
          trig_d   = 1'b1;
          state_d  = TRIG_ST_PULSE;
        end else begin
          done_d  = 1'b1;
          state_d = TRIG_ST_IDLE;
        end
      end
      TRIG_ST_PULSE: begin
        if (!wid_zero) begin
          wid_dec = 1'b1;
        end else begin
          trig_d = 1'b0;
`ifdef PW_TRIGGER_REPEAT_EN
          if (rep_q != '0) begin
            rep_d    = rep_q - R_ONE;
            gap_load = 1'b1;
            state_d  = TRIG_ST_GAP;
          end else begin
            done_d  = 1'b1;
            state_d = TRIG_ST_IDLE;
          end
`else
          done_d  = 1'b1;
          state_d = TRIG_ST_IDLE;
`endif
        end
      end
`ifdef PW_TRIGGER_REPEAT_EN
      TRIG_ST_GAP: begin
        if (!gap_zero) begin
          gap_dec = 1'b1;
        end else begin
          wid_load = 1'b1;
          trig_d   = 1'b1;
          state_d  = TRIG_ST_PULSE;
        end
      end
`endif
      default: begin
        trig_d  = 1'b0;
        state_d = TRIG_ST_IDLE;
      end
    endcase

    busy_d = (state_d != TRIG_ST_IDLE);

    // A match while a sequence is in flight sets the flag; set beats an arm rising edge.
    if (I_match && (state_q != TRIG_ST_IDLE)) begin
      missed_d = 1'b1;
    end else if (arm_rise) begin
      missed_d = 1'b0;
    end else begin
      missed_d = missed_q;
    end
  end

  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= TRIG_ST_IDLE;
      width_q  <= '0;
      trig_q   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      missed_q <= 1'b0;
      arm_q    <= 1'b0;
`ifdef PW_TRIGGER_REPEAT_EN
      rep_q    <= '0;
      gap_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      width_q  <= width_d;
      trig_q   <= trig_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      missed_q <= missed_d;
      arm_q    <= arm_d;
`ifdef PW_TRIGGER_REPEAT_EN
      rep_q    <= rep_d;
      gap_q    <= gap_d;
`endif
    end
  end

  pw_down_counter #(.pWIDTH(pTRIGGER_DELAY_WIDTH)) u_delay_cnt (
    .fe_clk   (fe_clk),
    .reset_n  (reset_n),
    .load     (dly_load),
    .load_val (I_trigger_delay),
    .dec      (dly_dec),
    .zero     (dly_zero)
  );

  // Loaded with W-1 so the final cycle at zero is the last high cycle.
  pw_down_counter #(.pWIDTH(pTRIGGER_WIDTH_WIDTH)) u_width_cnt (
    .fe_clk   (fe_clk),
    .reset_n  (reset_n),
    .load     (wid_load),
    .load_val (width_q - W_ONE),
    .dec      (wid_dec),
    .zero     (wid_zero)
  );

`ifdef PW_TRIGGER_REPEAT_EN
  pw_down_counter #(.pWIDTH(pTRIGGER_WIDTH_WIDTH)) u_gap_cnt (
    .fe_clk   (fe_clk),
    .reset_n  (reset_n),
    .load     (gap_load),
    .load_val (gap_q),
    .dec      (gap_dec),
    .zero     (gap_zero)
  );
`endif

  assign O_trigger = trig_q;
  assign O_busy    = busy_q;
  assign O_done    = done_q;
  assign O_missed  = missed_q;

endmodule

// File: tb/tb_pw_trigger_gen.sv
module tb_pw_trigger_gen;

  localparam int DW   = 8;
  localparam int WW   = 16;
  localparam int NCYC = 8192;

  logic          fe_clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          I_arm = 1'b0;
  logic          I_match = 1'b0;
  logic [DW-1:0] I_trigger_delay = '0;
  logic [WW-1:0] I_trigger_width = '0;
  logic          O_trigger, O_busy, O_done, O_missed;

  always #5 fe_clk = ~fe_clk;

  pw_trigger_gen #(
    .pTRIGGER_DELAY_WIDTH (DW),
    .pTRIGGER_WIDTH_WIDTH (WW)
  ) dut (
    .fe_clk          (fe_clk),
    .reset_n         (reset_n),
    .I_arm           (I_arm),
    .I_match         (I_match),
    .I_trigger_delay (I_trigger_delay),
    .I_trigger_width (I_trigger_width),
    .O_trigger       (O_trigger),
    .O_busy          (O_busy),
    .O_done          (O_done),
    .O_missed        (O_missed)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit mon_en = 1'b0;

  // Expected per-cycle outputs, indexed by the number of the edge that starts the cycle.
  bit exp_busy   [NCYC];
  bit exp_trig   [NCYC];
  bit exp_done   [NCYC];
  bit exp_missed [NCYC];

  typedef struct {
    int start;
    int width;
    int done;
  } seq_t;
  seq_t sb_q[$];
  seq_t mon_s;

  int last_end = -1000;   // last cycle of the sequence in flight (non-idle)
  bit prev_arm = 1'b0;

  int obs_start = 0, obs_len = 0;
  bit obs_prev_trig = 1'b0;
  int last_start = -1, last_len = -1, last_done = -1;

  task automatic chk(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference model: decide what the edge numbered e does with the inputs presented to it.
  task automatic model_edge(input int e, input bit m, input bit a, input int d, input int w);
    bit busy_prev;
    busy_prev = (e - 1 <= last_end);
    if (e < NCYC) begin
      if (m && busy_prev)        exp_missed[e] = 1'b1;
      else if (a && !prev_arm)   exp_missed[e] = 1'b0;
      else                       exp_missed[e] = exp_missed[e-1];
    end
    prev_arm = a;
    if (m && a && !busy_prev) begin
      seq_t s;
      for (int c = e; c <= e + d + w; c++)
        if (c < NCYC) exp_busy[c] = 1'b1;
      for (int c = e + 1 + d; c <= e + d + w; c++)
        if (c < NCYC) exp_trig[c] = 1'b1;
      if (e + 1 + d + w < NCYC) exp_done[e + 1 + d + w] = 1'b1;
      last_end = e + d + w;
      s.start = e + 1 + d;
      s.width = w;
      s.done  = e + 1 + d + w;
      sb_q.push_back(s);
    end
  endtask

  task automatic step(input bit m, input bit a, input int d, input int w);
    @(negedge fe_clk);
    I_match         = m;
    I_arm           = a;
    I_trigger_delay = DW'(d);
    I_trigger_width = WW'(w);
    model_edge(cyc + 1, m, a, d, w);
    @(posedge fe_clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b1, $urandom_range(0, 200), $urandom_range(0, 9));
  endtask

  task automatic idle_until(input int k);
    while (cyc + 1 < k) idle(1);
  endtask

  task automatic chk_seq(input string name, input int st, input int len, input int dn);
    chk({name, "_start"}, last_start, st);
    chk({name, "_len"},   last_len,   len);
    chk({name, "_done"},  last_done,  dn);
  endtask

  // Monitor: per-cycle comparison plus scoreboard pop on every O_done.
  always @(negedge fe_clk) begin
    if (mon_en) begin
      if (cyc < NCYC) begin
        chk("busy",   int'(O_busy),    int'(exp_busy[cyc]));
        chk("trig",   int'(O_trigger), int'(exp_trig[cyc]));
        chk("done",   int'(O_done),    int'(exp_done[cyc]));
        chk("missed", int'(O_missed),  int'(exp_missed[cyc]));
      end
      if (O_trigger) begin
        if (!obs_prev_trig) begin
          obs_start = cyc;
          obs_len   = 0;
        end
        obs_len++;
      end
      obs_prev_trig = O_trigger;
      if (O_done) begin
        if (sb_q.size() == 0) begin
          chk("done_unexpected", 1, 0);
        end else begin
          mon_s = sb_q.pop_front();
          chk("sb_done_cycle", cyc, mon_s.done);
          chk("sb_width", obs_len, mon_s.width);
          if (mon_s.width > 0) chk("sb_start", obs_start, mon_s.start);
          last_start = (mon_s.width > 0) ? obs_start : -1;
          last_len   = obs_len;
          last_done  = cyc;
        end
        obs_len = 0;
      end
    end
  end

  initial begin
    int k;
    #2 reset_n = 1'b0;
    #20;
    chk("rst_trigger", int'(O_trigger), 0);
    chk("rst_busy",    int'(O_busy),    0);
    chk("rst_done",    int'(O_done),    0);
    chk("rst_missed",  int'(O_missed),  0);
    @(negedge fe_clk) reset_n = 1'b1;
    @(posedge fe_clk);
    cyc    = 0;
    mon_en = 1'b1;

    // D=0, W=1, match at edge 10
    idle_until(10);
    step(1'b1, 1'b1, 0, 1);
    idle(5);
    chk_seq("d0w1", 11, 1, 12);

    // D=5, W=3, match at edge 20
    idle_until(20);
    step(1'b1, 1'b1, 5, 3);
    idle(12);
    chk_seq("d5w3", 26, 3, 29);

    // W=0, D=4: no pulse, done after the delay
    idle_until(40);
    step(1'b1, 1'b1, 4, 0);
    idle(8);
    chk_seq("w0", -1, 0, 45);

    // Second match in DELAY and a D=100 write mid-sequence
    idle_until(60);
    step(1'b1, 1'b1, 6, 3);
    step(1'b0, 1'b1, 100, 3);
    step(1'b0, 1'b1, 100, 3);
    step(1'b1, 1'b1, 100, 3);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 100, 7);
    chk_seq("inflight", 67, 3, 70);
    #1 chk("missed_set", int'(O_missed), 1);
    step(1'b0, 1'b0, 0, 1);
    #1 chk("missed_held_arm_low", int'(O_missed), 1);
    step(1'b0, 1'b1, 0, 1);
    #1 chk("missed_clr_on_arm_rise", int'(O_missed), 0);

    // Largest delay the counter can hold
    k = cyc + 1;
    step(1'b1, 1'b1, (1 << DW) - 1, 2);
    idle((1 << DW) + 4);
    chk_seq("maxd", k + (1 << DW), 2, k + (1 << DW) + 2);

    // Randomised traffic: arm toggles, matches while busy, config churn
    for (int i = 0; i < 1500; i++)
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 9) != 0),
           $urandom_range(0, 8), $urandom_range(0, 4));
    idle(20);

    // Asynchronous reset in the middle of a pulse
    k = cyc + 1;
    step(1'b1, 1'b1, 0, 10);
    idle(3);
    #1 chk("pre_reset_trigger", int'(O_trigger), 1);
    mon_en = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_trigger", int'(O_trigger), 0);
    chk("async_rst_busy",    int'(O_busy),    0);
    chk("async_rst_done",    int'(O_done),    0);
    chk("async_rst_missed",  int'(O_missed),  0);
    @(posedge fe_clk);
    @(negedge fe_clk) reset_n = 1'b1;
    @(posedge fe_clk);
    for (int c = cyc + 1; c < NCYC; c++) begin
      exp_busy[c] = 1'b0; exp_trig[c] = 1'b0; exp_done[c] = 1'b0; exp_missed[c] = 1'b0;
    end
    cyc           = cyc + 10;
    sb_q.delete();
    last_end      = -1000;
    prev_arm      = I_arm;
    obs_prev_trig = 1'b0;
    obs_len       = 0;
    last_start    = -1;
    last_len      = -1;
    last_done     = -1;
    mon_en        = 1'b1;

    // Clean sequence after reset
    k = cyc + 1;
    step(1'b1, 1'b1, 2, 2);
    idle(8);
    chk_seq("post_reset", k + 3, 2, k + 5);

    chk("sb_leftover", sb_q.size(), 0);
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
